// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI retirement trace buffer: filtered capture of retired instructions into a
// circular FIFO with arm/freeze/clear control and a valid/ready drain port.
module ibex_rvfi_trace_buf #(
  parameter int unsigned Depth     = 16,
  parameter bit          Overwrite = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rvfi_valid_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  input  logic [1:0]                 rvfi_mode_i,
  input  logic [1:0]                 cfg_filter_i,
  input  logic                       cfg_stop_on_trap_i,
  input  logic                       arm_i,
  input  logic                       clear_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [31:0]                rd_pc_o,
  output logic [31:0]                rd_insn_o,
  output logic [3:0]                 rd_flags_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       overflow_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StFrozen  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  // Entry layout: {trap, intr, mode[1:0], insn[31:0], pc[31:0]}; storage is never reset.
  logic [67:0]     mem_q [Depth];
  logic [67:0]     head_entry;

  logic filter_match;
  logic capture;
  logic pop;
  logic full;
  logic we;

  always_comb begin
    filter_match = 1'b0;
    unique case (cfg_filter_i)
      2'd0: filter_match = 1'b0;
      2'd1: filter_match = 1'b1;
      2'd2: filter_match = rvfi_trap_i | rvfi_intr_i;
      2'd3: filter_match = (rvfi_mode_i == 2'b11);
    endcase
  end

  assign capture = (state_q == StCapture) & rvfi_valid_i & filter_match;
  assign full    = (count_q == DepthCnt);
  assign pop     = (count_q != '0) & rd_ready_i;

  // Pointer/count/overflow next state; clear wins over everything else.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    if (clear_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (capture) begin
        if (!full || pop) begin
          we     = 1'b1;
          tail_d = tail_q + 1'b1;
        end else if (Overwrite) begin
          // Full without a pop: oldest entry is lost, head moves with tail.
          we         = 1'b1;
          tail_d     = tail_q + 1'b1;
          head_d     = head_q + 1'b1;
          overflow_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (pop && !we) begin
        count_d = count_q - 1'b1;
      end else if (we && !pop && !full) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[tail_q] <= {rvfi_trap_i, rvfi_intr_i, rvfi_mode_i, rvfi_insn_i, rvfi_pc_rdata_i};
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (arm_i) state_d = StCapture;
        StCapture: if (capture && rvfi_trap_i && cfg_stop_on_trap_i) state_d = StFrozen;
        StFrozen:  if (arm_i) state_d = StCapture;
        default:   state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    state_o = state_q;
  end

  // Read port is masked while empty so unreset storage never reaches the outputs.
  always_comb begin
    head_entry = mem_q[head_q];
    rd_valid_o = (count_q != '0);
    count_o    = count_q;
    overflow_o = overflow_q;
    rd_pc_o    = '0;
    rd_insn_o  = '0;
    rd_flags_o = '0;
    if (rd_valid_o) begin
      rd_pc_o    = head_entry[31:0];
      rd_insn_o  = head_entry[63:32];
      rd_flags_o = head_entry[67:64];
    end
  end

endmodule
